// File: rtl/video_pkg.sv
// Shared constants, types and address/colour helpers for the Spectrum-class video generator.
package video_pkg;

   // Default 48K raster timing.
   localparam logic [8:0] H_TOTAL_48K  = 9'd448;
   localparam logic [8:0] V_TOTAL_48K  = 9'd312;
   localparam logic [8:0] HB_START_48K = 9'd320;
   localparam logic [8:0] HB_END_48K   = 9'd416;
   localparam logic [8:0] HS_START_48K = 9'd344;
   localparam logic [8:0] HS_END_48K   = 9'd376;
   localparam logic [8:0] VB_START_48K = 9'd248;
   localparam logic [8:0] VB_END_48K   = 9'd256;
   localparam logic [8:0] VS_LINES_48K = 9'd4;
   localparam logic [8:0] IRQ_LEN_48K  = 9'd64;

   localparam logic [8:0] DISP_W  = 9'd256;
   localparam logic [8:0] DISP_H  = 9'd192;
   localparam logic [8:0] DISP_X0 = 9'd8;

   localparam logic [2:0] ATTR_BASE = 3'b110;

   localparam int G_IDX = 2;
   localparam int R_IDX = 1;
   localparam int B_IDX = 0;

   typedef enum logic [2:0] {
      PH_BITMAP   = 3'd0,
      PH_BM_LATCH = 3'd1,
      PH_AT_LATCH = 3'd2,
      PH_LOAD     = 3'd7
   } fetch_phase_e;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
      logic i;
   } rgbi_t;

   // Bitmap rows are interleaved: thirds, then pixel row, then character row.
   function automatic logic [12:0] bitmap_addr(input logic [7:0] y, input logic [4:0] c);
      return {y[7:6], y[2:0], y[5:3], c};
   endfunction

   function automatic logic [12:0] attr_addr(input logic [7:0] y, input logic [4:0] c);
      return {ATTR_BASE, y[7:3], c};
   endfunction

   function automatic rgbi_t grb_to_rgbi(input logic [2:0] grb, input logic intensity);
      rgbi_t o;
      o.r = grb[R_IDX];
      o.g = grb[G_IDX];
      o.b = grb[B_IDX];
      o.i = intensity;
      return o;
   endfunction

endpackage

// File: rtl/vid_timing.sv
// Raster timing: pixel/line counters, registered sync, blank and frame irq, and the flash counter.
module vid_timing
   import video_pkg::*;
#(
   parameter logic [8:0] H_TOTAL  = H_TOTAL_48K,
   parameter logic [8:0] V_TOTAL  = V_TOTAL_48K,
   parameter logic [8:0] HB_START = HB_START_48K,
   parameter logic [8:0] HB_END   = HB_END_48K,
   parameter logic [8:0] HS_START = HS_START_48K,
   parameter logic [8:0] HS_END   = HS_END_48K,
   parameter logic [8:0] VB_START = VB_START_48K,
   parameter logic [8:0] VB_END   = VB_END_48K,
   parameter logic [8:0] VS_LINES = VS_LINES_48K,
   parameter logic [8:0] IRQ_LEN  = IRQ_LEN_48K
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   output logic [8:0] hc,
   output logic [8:0] vc,
   output logic       blank_next,
   output logic       flash_phase,
   output logic       hsync,
   output logic       vsync,
   output logic       blank,
   output logic       irq
);

   logic [8:0] hc_r;
   logic [8:0] vc_r;
   logic [4:0] flash_r;
   logic       hsync_r;
   logic       vsync_r;
   logic       blank_r;
   logic       irq_r;

   logic       hc_last_s;
   logic       vc_last_s;
   logic       hsync_s;
   logic       vsync_s;
   logic       blank_s;
   logic       irq_s;

   // Decode the current raster position.
   always_comb begin
      hc_last_s = (hc_r == (H_TOTAL - 9'd1));
      vc_last_s = (vc_r == (V_TOTAL - 9'd1));
      hsync_s   = (hc_r >= HS_START) && (hc_r < HS_END);
      vsync_s   = (vc_r >= VB_START) && (vc_r < (VB_START + VS_LINES));
      blank_s   = ((hc_r >= HB_START) && (hc_r < HB_END)) ||
                  ((vc_r >= VB_START) && (vc_r < VB_END));
      irq_s     = (vc_r == VB_START) && (hc_r < IRQ_LEN);
   end

   // Pixel, line and frame counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         hc_r    <= 9'd0;
         vc_r    <= 9'd0;
         flash_r <= 5'd0;
      end else if (ce) begin
         if (hc_last_s) begin
            hc_r <= 9'd0;
            if (vc_last_s) begin
               vc_r    <= 9'd0;
               flash_r <= flash_r + 5'd1;
            end else begin
               vc_r <= vc_r + 9'd1;
            end
         end else begin
            hc_r <= hc_r + 9'd1;
         end
      end
   end

   // Registered so these line up with the colour outputs of the same position.
   always_ff @(posedge clock) begin
      if (reset) begin
         hsync_r <= 1'b0;
         vsync_r <= 1'b0;
         blank_r <= 1'b0;
         irq_r   <= 1'b0;
      end else if (ce) begin
         hsync_r <= hsync_s;
         vsync_r <= vsync_s;
         blank_r <= blank_s;
         irq_r   <= irq_s;
      end
   end

   assign hc          = hc_r;
   assign vc          = vc_r;
   assign blank_next  = blank_s;
   assign flash_phase = flash_r[4];
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign blank       = blank_r;
   assign irq         = irq_r;

endmodule

// File: rtl/video_gen.sv
// Spectrum-class pixel/attribute fetch and RGBI raster generator.
// Optional floating-bus output enabled by defining VIDEO_FLOATBUS_EN.
module video_gen
   import video_pkg::*;
#(
   parameter logic [8:0] H_TOTAL  = H_TOTAL_48K,
   parameter logic [8:0] V_TOTAL  = V_TOTAL_48K,
   parameter logic [8:0] HB_START = HB_START_48K,
   parameter logic [8:0] HB_END   = HB_END_48K,
   parameter logic [8:0] HS_START = HS_START_48K,
   parameter logic [8:0] HS_END   = HS_END_48K,
   parameter logic [8:0] VB_START = VB_START_48K,
   parameter logic [8:0] VB_END   = VB_END_48K,
   parameter logic [8:0] VS_LINES = VS_LINES_48K,
   parameter logic [8:0] IRQ_LEN  = IRQ_LEN_48K
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [2:0]  border,
   output logic [12:0] a,
   input  logic [7:0]  d,
   output logic        r,
   output logic        g,
   output logic        b,
   output logic        i,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
`ifdef VIDEO_FLOATBUS_EN
   output logic [7:0]  bus,
`endif
   output logic        irq
);

   logic [8:0]  hc_s;
   logic [8:0]  vc_s;
   logic        blank_next_s;
   logic        flash_phase_s;

   logic        fetch_win_s;
   logic        disp_win_s;
   logic [4:0]  col_s;
   logic [7:0]  line_s;
   logic        inv_s;
   logic        pix_s;
   rgbi_t       colour_s;

   logic [12:0] a_r;
   logic [7:0]  bm_latch_r;
   logic [7:0]  at_latch_r;
   logic [7:0]  shift_r;
   logic [7:0]  attr_r;
   rgbi_t       colour_r;

   vid_timing #(
      .H_TOTAL  (H_TOTAL),
      .V_TOTAL  (V_TOTAL),
      .HB_START (HB_START),
      .HB_END   (HB_END),
      .HS_START (HS_START),
      .HS_END   (HS_END),
      .VB_START (VB_START),
      .VB_END   (VB_END),
      .VS_LINES (VS_LINES),
      .IRQ_LEN  (IRQ_LEN)
   ) u_timing (
      .clock       (clock),
      .reset       (reset),
      .ce          (ce),
      .hc          (hc_s),
      .vc          (vc_s),
      .blank_next  (blank_next_s),
      .flash_phase (flash_phase_s),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .irq         (irq)
   );

   // Fetch runs one character column ahead of the displayed column.
   always_comb begin
      fetch_win_s = (vc_s < DISP_H) && (hc_s < DISP_W);
      disp_win_s  = (vc_s < DISP_H) && (hc_s >= DISP_X0) && (hc_s < (DISP_X0 + DISP_W));
      col_s       = hc_s[7:3];
      line_s      = vc_s[7:0];
   end

   // Address generation and bitmap/attribute latches.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_r        <= 13'd0;
         bm_latch_r <= 8'd0;
         at_latch_r <= 8'd0;
      end else if (ce && fetch_win_s) begin
         case (hc_s[2:0])
            PH_BITMAP: begin
               a_r <= bitmap_addr(line_s, col_s);
            end
            PH_BM_LATCH: begin
               bm_latch_r <= d;
               a_r        <= attr_addr(line_s, col_s);
            end
            PH_AT_LATCH: begin
               at_latch_r <= d;
            end
            default: begin
               a_r <= a_r;
            end
         endcase
      end
   end

   // Pixel shifter and the attribute that applies to it.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_r <= 8'd0;
         attr_r  <= 8'd0;
      end else if (ce) begin
         if (fetch_win_s && (hc_s[2:0] == PH_LOAD)) begin
            shift_r <= bm_latch_r;
            attr_r  <= at_latch_r;
         end else begin
            shift_r <= {shift_r[6:0], 1'b0};
         end
      end
   end

   // Colour select: flash inverts the pixel, blanking overrides everything.
   always_comb begin
      inv_s    = attr_r[7] & flash_phase_s;
      pix_s    = shift_r[7] ^ inv_s;
      colour_s = rgbi_t'(4'b0000);
      if (blank_next_s) begin
         colour_s = rgbi_t'(4'b0000);
      end else if (disp_win_s) begin
         if (pix_s) begin
            colour_s = grb_to_rgbi(attr_r[2:0], attr_r[6]);
         end else begin
            colour_s = grb_to_rgbi(attr_r[5:3], attr_r[6]);
         end
      end else begin
         colour_s = grb_to_rgbi(border, 1'b0);
      end
   end

   // Colour output register.
   always_ff @(posedge clock) begin
      if (reset) begin
         colour_r <= rgbi_t'(4'b0000);
      end else if (ce) begin
         colour_r <= colour_s;
      end
   end

`ifdef VIDEO_FLOATBUS_EN
   logic [7:0] bus_r;

   // Floating bus shows the byte the ULA is reading, otherwise idles high.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus_r <= 8'hFF;
      end else if (ce) begin
         if (fetch_win_s && ((hc_s[2:0] == PH_BM_LATCH) || (hc_s[2:0] == PH_AT_LATCH))) begin
            bus_r <= d;
         end else begin
            bus_r <= 8'hFF;
         end
      end
   end

   assign bus = bus_r;
`endif

   assign a = a_r;
   assign r = colour_r.r;
   assign g = colour_r.g;
   assign b = colour_r.b;
   assign i = colour_r.i;

endmodule
